// File: rtl/port_pkg.sv
// ============================================================================
//  Module   : port_pkg
//  Brief    : Shared queue count, dispatcher "none" code and read-FSM states.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package port_pkg;

  localparam int         QUEUE_NUM  = 4;
  localparam int         QIDX_W     = 2;
  localparam logic [2:0] PRIOR_NONE = 3'd4;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SELECT = 2'd1,
    ST_REQ    = 2'd2,
    ST_XFER   = 2'd3
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/queue_pkt_counter.sv
// ============================================================================
//  Module   : queue_pkt_counter
//  Brief    : Saturating per-queue packet counter with sticky overflow flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module queue_pkt_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             empty,
  output logic             ovf
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_full;

  assign w_full = &r_cnt;

  // Simultaneous inc and dec cancel; dec at zero holds rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (inc && !dec) begin
      if (w_full) r_ovf <= 1'b1;
      else        r_cnt <= r_cnt + 1'b1;
    end else if (dec && !inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt   = r_cnt;
  assign empty = (r_cnt == '0);
  assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/port_rd_frontend.sv
// ============================================================================
//  Module   : port_rd_frontend
//  Brief    : Per-port read front end: queue occupancy, dispatcher handshake,
//             read request issue. Optional XFER watchdog: PORT_RD_TIMEOUT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module port_rd_frontend
  import port_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int SETTLE_CYC  = 7,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              port_en,
  input  logic              wr_pkt_en,
  input  logic [QIDX_W-1:0] wr_pkt_queue,
  input  logic [2:0]        prior_next,
  output logic [QUEUE_NUM-1:0] queue_empty,
  output logic              prior_update,
  output logic              rd_req,
  output logic [QIDX_W-1:0] rd_req_queue,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              rd_abort,
  output logic              cnt_ovf
);

  localparam int SET_W = ($clog2(SETTLE_CYC + 1) > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYC);

  rd_state_e         r_state, w_state_nxt;
  logic [SET_W-1:0]  r_settle, w_settle_nxt;
  logic              r_rd_req, w_rd_req_nxt;
  logic [QIDX_W-1:0] r_rd_q, w_rd_q_nxt;
  logic              r_prior_update, w_prior_update_nxt;
  logic [QUEUE_NUM-1:0] w_empty, w_ovf, w_inc, w_dec;
  logic              w_sel_ok, w_ack_hit;

  assign w_sel_ok  = port_en && (prior_next < PRIOR_NONE) && !w_empty[prior_next[QIDX_W-1:0]];
  assign w_ack_hit = (r_state == ST_REQ) && rd_ack;

  for (genvar gi = 0; gi < QUEUE_NUM; gi++) begin : g_cnt
    assign w_inc[gi] = wr_pkt_en && (wr_pkt_queue == QIDX_W'(gi));
    assign w_dec[gi] = w_ack_hit && (r_rd_q == QIDX_W'(gi));

    queue_pkt_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_inc[gi]),
      .dec   (w_dec[gi]),
      .cnt   (),
      .empty (w_empty[gi]),
      .ovf   (w_ovf[gi])
    );
  end

`ifdef PORT_RD_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYC + 1) > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);
  logic [WD_W-1:0] r_wdog, w_wdog_nxt;
  logic            r_rd_abort, w_abort_nxt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

  always_comb begin
    w_state_nxt        = r_state;
    w_settle_nxt       = r_settle;
    w_rd_req_nxt       = r_rd_req;
    w_rd_q_nxt         = r_rd_q;
    w_prior_update_nxt = 1'b0;
`ifdef PORT_RD_TIMEOUT_EN
    w_wdog_nxt  = r_wdog;
    w_abort_nxt = 1'b0;
`endif
    case (r_state)
      ST_SETTLE: begin
        if (r_settle == '0) w_state_nxt  = ST_SELECT;
        else                w_settle_nxt = r_settle - 1'b1;
      end
      ST_SELECT: begin
        if (w_sel_ok) begin
          w_rd_req_nxt = 1'b1;
          w_rd_q_nxt   = prior_next[QIDX_W-1:0];
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        // port_en is deliberately ignored here: an issued request is never withdrawn.
        if (rd_ack) begin
          w_rd_req_nxt       = 1'b0;
          w_prior_update_nxt = 1'b1;
          w_state_nxt        = ST_XFER;
`ifdef PORT_RD_TIMEOUT_EN
          w_wdog_nxt = '0;
`endif
        end
      end
      ST_XFER: begin
        if (rd_done) begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = SETTLE_INIT;
        end
`ifdef PORT_RD_TIMEOUT_EN
        else if (r_wdog == WD_MAX) begin
          w_abort_nxt  = 1'b1;
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = SETTLE_INIT;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt  = ST_SETTLE;
        w_settle_nxt = SETTLE_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_SETTLE;
      r_settle       <= SETTLE_INIT;
      r_rd_req       <= 1'b0;
      r_rd_q         <= '0;
      r_prior_update <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_settle       <= w_settle_nxt;
      r_rd_req       <= w_rd_req_nxt;
      r_rd_q         <= w_rd_q_nxt;
      r_prior_update <= w_prior_update_nxt;
    end
  end

`ifdef PORT_RD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog     <= '0;
      r_rd_abort <= 1'b0;
    end else begin
      r_wdog     <= w_wdog_nxt;
      r_rd_abort <= w_abort_nxt;
    end
  end
  assign rd_abort = r_rd_abort;
`else
  assign rd_abort = 1'b0;
`endif

  assign queue_empty  = w_empty;
  assign prior_update = r_prior_update;
  assign rd_req       = r_rd_req;
  assign rd_req_queue = r_rd_q;
  assign cnt_ovf      = |w_ovf;

endmodule

`default_nettype wire
